sram_arbiter: RTL and testbench



---
 rtl/sram_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//   Shares one 1M x 16 asynchronous SRAM between two requesters using
//   round-robin arbitration. It also sequences the CE/OE/WE/LB/UB strobes:
//     IDLE -> SETUP -> ACCESS (ACCESS_CYCLES clocks) -> DONE -> IDLE.
//   Every pin-facing output comes straight from a flop.
//
// Parameters
//   ACCESS_CYCLES : width of the OE/WE-active phase in clocks (1..15).
//
// Ports
//   clk, reset_n            : clock, asynchronous active-low reset
//   pN_req/we/addr/wdata/be : requester N transaction (N = 0, 1)
//   pN_ack, pN_rdata        : completion pulse, read data (held until next read)
//   busy                    : FSM not in IDLE
//   sram_*                  : SRAM pins (DQ bidirectional, strobes active-low)
// ---------------------------------------------------------------------------
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [19:0] p0_addr,
  input  logic [15:0] p0_wdata,
  input  logic [1:0]  p0_be,
  output logic        p0_ack,
  output logic [15:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [19:0] p1_addr,
  input  logic [15:0] p1_wdata,
  input  logic [1:0]  p1_be,
  output logic        p1_ack,
  output logic [15:0] p1_rdata,
  output logic        busy,
  inout  wire  [15:0] sram_DQ,
  output logic [19:0] sram_ADDR,
  output logic        sram_CE_N,
  output logic        sram_OE_N,
  output logic        sram_WE_N,
  output logic        sram_LB_N,
  output logic        sram_UB_N
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

  localparam logic [3:0] LP_CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;

  // Latched transaction
  logic        r_gnt;
  logic        r_last_grant;
  logic        r_we;
  logic [19:0] r_addr;
  logic [15:0] r_wdata;
  logic [1:0]  r_be;
  logic [3:0]  r_cnt;
  logic [15:0] r_p0_rdata;
  logic [15:0] r_p1_rdata;

  // Registered pin / handshake outputs
  logic        r_ce_n, r_oe_n, r_we_n, r_lb_n, r_ub_n, r_dq_oe;
  logic        r_p0_ack, r_p1_ack;

  // Arbitration and the values that will be latched on a grant
  logic        w_grant_fire;
  logic        w_grant_port;
  logic        w_sel_we;
  logic [19:0] w_sel_addr;
  logic [15:0] w_sel_wdata;
  logic [1:0]  w_sel_be;
  logic        w_we_eff;
  logic [1:0]  w_be_eff;

  // Next values for the registered outputs
  logic        w_ce_n_next, w_oe_n_next, w_we_n_next, w_lb_n_next, w_ub_n_next;
  logic        w_dq_oe_next, w_p0_ack_next, w_p1_ack_next;

  assign w_grant_fire = (r_state == S_IDLE) && (p0_req || p1_req);
  // On a tie the port that did not win last time gets the bus.
  assign w_grant_port = (p0_req && p1_req) ? ~r_last_grant : p1_req;
  assign w_sel_we     = w_grant_port ? p1_we    : p0_we;
  assign w_sel_addr   = w_grant_port ? p1_addr  : p0_addr;
  assign w_sel_wdata  = w_grant_port ? p1_wdata : p0_wdata;
  assign w_sel_be     = w_grant_port ? p1_be    : p0_be;

  // Strobes for SETUP are registered on the grant edge, before the latch
  // registers hold the new transaction, so look through to the selection.
  assign w_we_eff = w_grant_fire ? w_sel_we : r_we;
  assign w_be_eff = w_grant_fire ? w_sel_be : r_be;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (p0_req || p1_req) w_state_next = S_SETUP;
      S_SETUP:  w_state_next = S_ACCESS;
      S_ACCESS: if (r_cnt == 4'd0) w_state_next = S_DONE;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Output logic, evaluated for the state being entered
  always_comb begin
    w_ce_n_next   = 1'b1;
    w_oe_n_next   = 1'b1;
    w_we_n_next   = 1'b1;
    w_lb_n_next   = 1'b1;
    w_ub_n_next   = 1'b1;
    w_dq_oe_next  = 1'b0;
    w_p0_ack_next = 1'b0;
    w_p1_ack_next = 1'b0;
    case (w_state_next)
      S_SETUP, S_ACCESS: begin
        w_ce_n_next  = 1'b0;
        w_oe_n_next  = w_we_eff;
        w_we_n_next  = ~(w_we_eff && (w_state_next == S_ACCESS));
        w_lb_n_next  = ~w_be_eff[0];
        w_ub_n_next  = ~w_be_eff[1];
        w_dq_oe_next = w_we_eff;
      end
      S_DONE: begin
        // Keep write data on the bus one cycle past the WE_N rising edge.
        w_dq_oe_next  = r_we;
        w_p0_ack_next = ~r_gnt;
        w_p1_ack_next = r_gnt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ce_n   <= 1'b1;
      r_oe_n   <= 1'b1;
      r_we_n   <= 1'b1;
      r_lb_n   <= 1'b1;
      r_ub_n   <= 1'b1;
      r_dq_oe  <= 1'b0;
      r_p0_ack <= 1'b0;
      r_p1_ack <= 1'b0;
    end else begin
      r_ce_n   <= w_ce_n_next;
      r_oe_n   <= w_oe_n_next;
      r_we_n   <= w_we_n_next;
      r_lb_n   <= w_lb_n_next;
      r_ub_n   <= w_ub_n_next;
      r_dq_oe  <= w_dq_oe_next;
      r_p0_ack <= w_p0_ack_next;
      r_p1_ack <= w_p1_ack_next;
    end
  end

  // Transaction latch, access counter and read capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
      r_gnt        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= 20'd0;
      r_wdata      <= 16'd0;
      r_be         <= 2'b00;
      r_cnt        <= 4'd0;
      r_p0_rdata   <= 16'd0;
      r_p1_rdata   <= 16'd0;
    end else begin
      if (w_grant_fire) begin
        r_last_grant <= w_grant_port;
        r_gnt        <= w_grant_port;
        r_we         <= w_sel_we;
        r_addr       <= w_sel_addr;
        r_wdata      <= w_sel_wdata;
        r_be         <= w_sel_be;
      end
      if (r_state == S_SETUP)
        r_cnt <= LP_CNT_LOAD;
      else if (r_state == S_ACCESS && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      // Capture on the edge that closes the last ACCESS cycle.
      if (r_state == S_ACCESS && w_state_next == S_DONE && !r_we) begin
        if (r_gnt) r_p1_rdata <= sram_DQ;
        else       r_p0_rdata <= sram_DQ;
      end
    end
  end

  assign sram_DQ   = r_dq_oe ? r_wdata : 16'bz;
  assign sram_ADDR = r_addr;
  assign sram_CE_N = r_ce_n;
  assign sram_OE_N = r_oe_n;
  assign sram_WE_N = r_we_n;
  assign sram_LB_N = r_lb_n;
  assign sram_UB_N = r_ub_n;
  assign p0_ack    = r_p0_ack;
  assign p1_ack    = r_p1_ack;
  assign p0_rdata  = r_p0_rdata;
  assign p1_rdata  = r_p1_rdata;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
module tb_sram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [19:0] p0_addr, p1_addr;
  logic [15:0] p0_wdata, p1_wdata;
  logic [1:0]  p0_be, p1_be;
  logic        p0_ack, p1_ack, busy;
  logic [15:0] p0_rdata, p1_rdata;
  wire  [15:0] sram_DQ;
  logic [19:0] sram_ADDR;
  logic        sram_CE_N, sram_OE_N, sram_WE_N, sram_LB_N, sram_UB_N;

  sram_arbiter #(.ACCESS_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .busy(busy), .sram_DQ(sram_DQ), .sram_ADDR(sram_ADDR),
    .sram_CE_N(sram_CE_N), .sram_OE_N(sram_OE_N), .sram_WE_N(sram_WE_N),
    .sram_LB_N(sram_LB_N), .sram_UB_N(sram_UB_N)
  );

  // Second instance with a one-cycle access phase, port 0 only
  logic        q_req;
  logic [19:0] q_addr;
  logic        q_ack, q1_ack, q_busy;
  logic [15:0] q_rdata, q1_rdata;
  wire  [15:0] sram1_DQ;
  logic [19:0] sram1_ADDR;
  logic        s1_ce_n, s1_oe_n, s1_we_n, s1_lb_n, s1_ub_n;

  sram_arbiter #(.ACCESS_CYCLES(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .p0_req(q_req), .p0_we(1'b0), .p0_addr(q_addr), .p0_wdata(16'h0000), .p0_be(2'b11),
    .p0_ack(q_ack), .p0_rdata(q_rdata),
    .p1_req(1'b0), .p1_we(1'b0), .p1_addr(20'h00000), .p1_wdata(16'h0000), .p1_be(2'b00),
    .p1_ack(q1_ack), .p1_rdata(q1_rdata),
    .busy(q_busy), .sram_DQ(sram1_DQ), .sram_ADDR(sram1_ADDR),
    .sram_CE_N(s1_ce_n), .sram_OE_N(s1_oe_n), .sram_WE_N(s1_we_n),
    .sram_LB_N(s1_lb_n), .sram_UB_N(s1_ub_n)
  );

  // SRAM models (low 8 address bits decoded)
  logic [15:0] mem0 [0:255];
  logic [15:0] mem1 [0:255];
  assign sram_DQ  = (!sram_CE_N && !sram_OE_N && sram_WE_N) ? mem0[sram_ADDR[7:0]] : 16'bz;
  assign sram1_DQ = (!s1_ce_n && !s1_oe_n && s1_we_n) ? mem1[sram1_ADDR[7:0]] : 16'bz;
  always @(negedge clk) begin
    if (!sram_CE_N && !sram_WE_N) begin
      if (!sram_LB_N) mem0[sram_ADDR[7:0]][7:0]  <= sram_DQ[7:0];
      if (!sram_UB_N) mem0[sram_ADDR[7:0]][15:8] <= sram_DQ[15:8];
    end
  end

  // Cycle counter and pin activity monitors
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int we_lo = 0, oe_lo = 0, lb_lo = 0, ub_lo = 0, dq_drv = 0, dq_bad = 0, both_ack = 0;
  logic [15:0] dq_expect = 16'h0000;
  always @(negedge clk) begin
    if (!sram_WE_N) we_lo <= we_lo + 1;
    if (!sram_OE_N) oe_lo <= oe_lo + 1;
    if (!sram_LB_N) lb_lo <= lb_lo + 1;
    if (!sram_UB_N) ub_lo <= ub_lo + 1;
    if (dut.r_dq_oe) begin
      dq_drv <= dq_drv + 1;
      if (sram_DQ !== dq_expect) dq_bad <= dq_bad + 1;
    end
    if (p0_ack && p1_ack) both_ack <= both_ack + 1;
  end

  int b_we, b_oe, b_lb, b_ub, b_drv, b_bad, b_both;
  task automatic snap();
    b_we = we_lo; b_oe = oe_lo; b_lb = lb_lo; b_ub = ub_lo;
    b_drv = dq_drv; b_bad = dq_bad; b_both = both_ack;
  endtask

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction on dut; lat = cycles from request to ack (-1 on timeout)
  task automatic txn(input int port, input logic we, input logic [19:0] addr,
                     input logic [15:0] wd, input logic [1:0] be,
                     output int lat, output logic [15:0] rd);
    int start;
    bit got;
    @(posedge clk); #1;
    if (port == 0) begin
      p0_we = we; p0_addr = addr; p0_wdata = wd; p0_be = be; p0_req = 1'b1;
    end else begin
      p1_we = we; p1_addr = addr; p1_wdata = wd; p1_be = be; p1_req = 1'b1;
    end
    start = cyc; got = 1'b0; lat = -1; rd = 16'h0000;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if ((port == 0 && p0_ack) || (port == 1 && p1_ack)) begin
        got = 1'b1; lat = cyc - start; rd = (port == 0) ? p0_rdata : p1_rdata;
      end
    end
    @(posedge clk); #1;
    p0_req = 1'b0; p1_req = 1'b0;
    @(posedge clk); #1;
    $display("txn port=%0d we=%0d addr=%05h wdata=%04h be=%02b lat=%0d rdata=%04h",
             port, we, addr, wd, be, lat, rd);
  endtask

  int          lat;
  logic [15:0] rd;
  int          order [4];
  int          ack_cyc [4];
  int          n_acks;
  bit          seen;

  initial begin
    reset_n = 1'b0;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_be = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_be = 0;
    q_req = 0; q_addr = 0;
    for (int i = 0; i < 256; i++) mem1[i] = 16'hA000 + 16'(i);

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("rst_strobes", {sram_CE_N, sram_OE_N, sram_WE_N, sram_LB_N, sram_UB_N}, 5'b11111);
    check("rst_addr", sram_ADDR, 20'h00000);
    check("rst_acks", {p0_ack, p1_ack}, 2'b00);
    check("rst_rdata", {p0_rdata, p1_rdata}, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_dq_oe", dut.r_dq_oe, 1'b0);
    $display("reset state checked");
    reset_n = 1'b1;

    // Full-word write on port 0
    dq_expect = 16'hBEEF;
    snap();
    txn(0, 1'b1, 20'h00010, 16'hBEEF, 2'b11, lat, rd);
    check("wr_latency", lat, 4);
    check("wr_we_low", we_lo - b_we, 2);
    check("wr_oe_low", oe_lo - b_oe, 0);
    check("wr_dq_cycles", dq_drv - b_drv, 4);
    check("wr_dq_value", dq_bad - b_bad, 0);
    check("wr_mem", mem0[8'h10], 16'hBEEF);

    // Read on port 1
    snap();
    txn(1, 1'b0, 20'h00010, 16'h0000, 2'b11, lat, rd);
    check("rd_latency", lat, 4);
    check("rd_oe_low", oe_lo - b_oe, 3);
    check("rd_we_low", we_lo - b_we, 0);
    check("rd_dq_driven", dq_drv - b_drv, 0);
    check("rd_data_at_ack", rd, 16'hBEEF);
    check("rd_p0_untouched", p0_rdata, 16'h0000);

    // Continuous tie: both ports read
    snap();
    @(posedge clk); #1;
    p0_we = 0; p0_addr = 20'h00010; p0_be = 2'b11; p0_req = 1;
    p1_we = 0; p1_addr = 20'h00010; p1_be = 2'b11; p1_req = 1;
    n_acks = 0;
    for (int i = 0; i < 60 && n_acks < 4; i++) begin
      @(negedge clk);
      if (p0_ack || p1_ack) begin
        order[n_acks] = p1_ack ? 1 : 0;
        ack_cyc[n_acks] = cyc;
        $display("tie ack #%0d port=%0d cycle=%0d", n_acks, order[n_acks], cyc);
        n_acks++;
      end
    end
    @(posedge clk); #1; p0_req = 0; p1_req = 0;
    @(posedge clk); #1;
    check("tie_count", n_acks, 4);
    check("tie_order", {order[0][1:0], order[1][1:0], order[2][1:0], order[3][1:0]}, 8'b00010001);
    for (int k = 1; k < 4; k++) check("tie_spacing", ack_cyc[k] - ack_cyc[k-1], 5);
    check("tie_both_ack", both_ack - b_both, 0);

    // Upper-byte write then read back
    dq_expect = 16'h12AB;
    snap();
    txn(0, 1'b1, 20'h00010, 16'h12AB, 2'b10, lat, rd);
    check("bw_latency", lat, 4);
    check("bw_lb_low", lb_lo - b_lb, 0);
    check("bw_ub_low", ub_lo - b_ub, 3);
    check("bw_mem", mem0[8'h10], 16'h12EF);
    txn(0, 1'b0, 20'h00010, 16'h0000, 2'b11, lat, rd);
    check("bw_readback", rd, 16'h12EF);
    check("bw_p1_untouched", p1_rdata, 16'hBEEF);

    // Reset during the ACCESS phase of a write
    @(posedge clk); #1;
    p0_we = 1; p0_addr = 20'h00020; p0_wdata = 16'h5555; p0_be = 2'b11; p0_req = 1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (!sram_WE_N) seen = 1'b1;
    end
    check("abort_in_access", seen, 1'b1);
    check("abort_busy_before", busy, 1'b1);
    reset_n = 1'b0; p0_req = 0;
    #1;
    check("abort_strobes", {sram_CE_N, sram_OE_N, sram_WE_N, sram_LB_N, sram_UB_N}, 5'b11111);
    check("abort_dq_oe", dut.r_dq_oe, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_acks", {p0_ack, p1_ack}, 2'b00);
    check("abort_addr", sram_ADDR, 20'h00000);
    check("abort_rdata", {p0_rdata, p1_rdata}, 32'h0);
    $display("reset asserted mid-write");
    @(posedge clk); #1; reset_n = 1'b1;
    p0_we = 0; p0_addr = 20'h00010; p0_be = 2'b11; p0_req = 1;
    p1_we = 0; p1_addr = 20'h00010; p1_be = 2'b11; p1_req = 1;
    n_acks = 0;
    for (int i = 0; i < 30 && n_acks < 1; i++) begin
      @(negedge clk);
      if (p0_ack || p1_ack) begin
        order[0] = p1_ack ? 1 : 0;
        order[1] = (p0_ack && p1_ack) ? 1 : 0;
        n_acks++;
      end
    end
    @(posedge clk); #1; p0_req = 0; p1_req = 0;
    @(posedge clk); #1;
    $display("post-reset tie first grant port=%0d", order[0]);
    check("post_rst_first", order[0], 0);
    check("post_rst_single", order[1], 0);
    check("post_rst_rdata", p0_rdata, 16'h12EF);

    // ACCESS_CYCLES = 1, back-to-back reads on port 0
    @(posedge clk); #1;
    q_addr = 20'h00001; q_req = 1;
    lat = cyc;
    n_acks = 0;
    for (int i = 0; i < 40 && n_acks < 3; i++) begin
      @(negedge clk);
      if (q_ack) begin
        $display("ac1 read #%0d addr=%05h rdata=%04h cycle=%0d", n_acks, q_addr, q_rdata, cyc);
        check("ac1_rdata", q_rdata, 16'hA000 + 16'(n_acks + 1));
        ack_cyc[n_acks] = cyc;
        n_acks++;
        @(posedge clk); #1;
        if (n_acks < 3) q_addr = 20'(n_acks + 1);
        else q_req = 0;
      end
    end
    q_req = 0;
    check("ac1_count", n_acks, 3);
    check("ac1_latency", ack_cyc[0] - lat, 3);
    check("ac1_spacing1", ack_cyc[1] - ack_cyc[0], 4);
    check("ac1_spacing2", ack_cyc[2] - ack_cyc[1], 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
